// File: rtl/cache_traffic_gen.sv
// cache_traffic_gen: built-in cache exerciser.
// Writes a deterministic pattern to NUM_OPS addresses, reads them back in the
// same order, counts mismatches and flags any request that waits too long.
// Optional macro CACHE_TG_RAND_EN: addresses come from a 16-bit Galois LFSR
// (reseeded for the read pass) instead of the linear BASE_ADDR/STRIDE walk.
module cache_traffic_gen #(
  parameter int          ADDR_W    = 16,
  parameter int          BLOCK_W   = 256,
  parameter int          NUM_OPS   = 256,
  parameter logic [15:0] BASE_ADDR = 16'h1000,
  parameter int          STRIDE    = 1,
  parameter int          TIMEOUT   = 1024,
  parameter logic [15:0] SEED      = 16'hA5C3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               memReady,
  input  logic [BLOCK_W-1:0] outblock,
  output logic               write,
  output logic               read,
  output logic               memaccess,
  output logic [ADDR_W-1:0]  address,
  output logic [BLOCK_W-1:0] inblock,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [15:0]        err_cnt
);

  localparam int WORDS = BLOCK_W / 32;
  localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_REQ, ST_WR_GAP, ST_RD_REQ, ST_RD_GAP, ST_DONE, ST_FAIL
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]  cur_addr;
  logic               last_op;
  logic               tmo_hit;

  // Word k of the block for address a: {a, SEED+k}, word 0 in the low bits.
  function automatic logic [BLOCK_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [BLOCK_W-1:0] p;
    p = '0;
    for (int k = 0; k < WORDS; k++) p[k*32 +: 32] = {16'(a), SEED + 16'(k)};
    return p;
  endfunction

`ifdef CACHE_TG_RAND_EN
  localparam int AQ_W = 16;
  localparam logic [AQ_W-1:0] ADDR_SEED = BASE_ADDR | 16'h0001;

  // Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting form.
  function automatic logic [AQ_W-1:0] addr_step(input logic [AQ_W-1:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction
`else
  localparam int AQ_W = ADDR_W;
  localparam logic [AQ_W-1:0] ADDR_SEED = AQ_W'(BASE_ADDR);

  // Linear walk; the adder width gives the modulo-2^ADDR_W wrap for free.
  function automatic logic [AQ_W-1:0] addr_step(input logic [AQ_W-1:0] s);
    return s + AQ_W'(STRIDE);
  endfunction
`endif

  logic [AQ_W-1:0] addr_q;

  assign cur_addr = addr_q[ADDR_W-1:0];
  assign last_op  = (idx == LAST_IDX);
  assign tmo_hit  = (wait_cnt == TMO_LAST);

  // State register; reset overrides everything, including a live request.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode and request/status outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_next = state;
    write      = 1'b0;
    read       = 1'b0;
    memaccess  = 1'b0;
    address    = '0;
    inblock    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) state_next = ST_WR_REQ;
        done    = (state != ST_IDLE);
        pass    = (state == ST_DONE) && (err_cnt == 16'h0000);
        timeout = (state == ST_FAIL);
      end
      ST_WR_REQ: begin
        busy      = 1'b1;
        memaccess = 1'b1;
        write     = 1'b1;
        address   = cur_addr;
        inblock   = pattern(cur_addr);
        if (memReady)     state_next = ST_WR_GAP;
        else if (tmo_hit) state_next = ST_FAIL;
      end
      ST_WR_GAP: begin
        busy       = 1'b1;
        state_next = last_op ? ST_RD_REQ : ST_WR_REQ;
      end
      ST_RD_REQ: begin
        busy      = 1'b1;
        memaccess = 1'b1;
        read      = 1'b1;
        address   = cur_addr;
        if (memReady)     state_next = ST_RD_GAP;
        else if (tmo_hit) state_next = ST_FAIL;
      end
      ST_RD_GAP: begin
        busy       = 1'b1;
        state_next = last_op ? ST_DONE : ST_RD_REQ;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Access index, address generator, wait counter and error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      addr_q   <= '0;
      wait_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (((state == ST_WR_REQ) || (state == ST_RD_REQ)) && !memReady)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            idx     <= '0;
            addr_q  <= ADDR_SEED;
            err_cnt <= '0;
          end
        end
        ST_WR_GAP, ST_RD_GAP: begin
          if (last_op) begin
            // Rewind so the read pass revisits the write order.
            idx    <= '0;
            addr_q <= ADDR_SEED;
          end else begin
            idx    <= idx + 1'b1;
            addr_q <= addr_step(addr_q);
          end
        end
        ST_RD_REQ: begin
          if (memReady && (outblock != pattern(cur_addr)) && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'h0001;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Self-checking bench for cache_traffic_gen: a table of directed runs, a
// mid-run reset sequence, randomized runs against a reference model, and a
// second instance exercising address wrap-around.
module tb_cache_traffic_gen;

  localparam int BW   = 256;
  localparam int NOPS = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: BASE 1000, cache model with latency / corruption / noise.
  logic          start_a, mem_ready_a, write_a, read_a, mem_access_a;
  logic          busy_a, done_a, pass_a, timeout_a;
  logic [BW-1:0] outblock_a, inblock_a;
  logic [15:0]   address_a, err_a;

  // Instance B: BASE FFFE, always-ready ideal cache.
  logic          start_b, mem_ready_b, write_b, read_b, mem_access_b;
  logic          busy_b, done_b, pass_b, timeout_b;
  logic [BW-1:0] outblock_b, inblock_b;
  logic [15:0]   address_b, err_b;

  cache_traffic_gen #(.ADDR_W(16), .BLOCK_W(BW), .NUM_OPS(NOPS), .BASE_ADDR(16'h1000),
                      .STRIDE(1), .TIMEOUT(TMO), .SEED(16'hA5C3)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .memReady(mem_ready_a),
    .outblock(outblock_a), .write(write_a), .read(read_a), .memaccess(mem_access_a),
    .address(address_a), .inblock(inblock_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .timeout(timeout_a), .err_cnt(err_a));

  cache_traffic_gen #(.ADDR_W(16), .BLOCK_W(BW), .NUM_OPS(NOPS), .BASE_ADDR(16'hFFFE),
                      .STRIDE(1), .TIMEOUT(TMO), .SEED(16'hA5C3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .memReady(mem_ready_b),
    .outblock(outblock_b), .write(write_b), .read(read_b), .memaccess(mem_access_b),
    .address(address_b), .inblock(inblock_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .timeout(timeout_b), .err_cnt(err_b));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: block contents for address a.
  function automatic logic [BW-1:0] pat(input logic [15:0] a);
    logic [BW-1:0] p;
    for (int k = 0; k < BW / 32; k++) p[32*k +: 32] = {a, 16'(32'hA5C3 + k)};
    return p;
  endfunction

  // Reference: i-th address of a pass, stride 1 modulo 2^16.
  function automatic logic [15:0] addr_ref(input logic [15:0] base, input int i);
    return 16'(int'(base) + i);
  endfunction

  // ---------------- cache model for instance A ----------------
  logic [BW-1:0] mem [logic [15:0]];
  int            corrupt_map [logic [15:0]];   // address -> bit to flip on read
  logic [15:0]   wr_log[$], rd_log[$];
  int            wr_data_bad;
  int            g_max_lat = 0, g_fix_lat = 0, g_noise = 0, g_stall = 0;
  int            wcnt = 0, cur_lat = 0;

  always @(negedge clk) begin
    logic [BW-1:0] blk;
    if (mem_access_a && g_stall == 0) begin
      if (wcnt >= cur_lat) begin
        mem_ready_a = 1'b1;
        if (write_a) begin
          if (inblock_a !== pat(address_a)) wr_data_bad++;
          mem[address_a] = inblock_a;
          wr_log.push_back(address_a);
        end else begin
          blk = mem.exists(address_a) ? mem[address_a] : '0;
          if (corrupt_map.exists(address_a))
            blk[corrupt_map[address_a]] = ~blk[corrupt_map[address_a]];
          outblock_a = blk;
          rd_log.push_back(address_a);
        end
      end else begin
        mem_ready_a = 1'b0;
        outblock_a  = {8{$urandom()}};
        wcnt++;
      end
    end else begin
      mem_ready_a = (g_noise != 0) ? 1'($urandom_range(1, 0)) : 1'b0;
      outblock_a  = {8{$urandom()}};
      wcnt        = 0;
      cur_lat     = (g_fix_lat != 0) ? g_max_lat : int'($urandom_range(g_max_lat, 0));
    end
  end

  // ---------------- ideal cache model for instance B ----------------
  logic [15:0] wr_log_b[$], rd_log_b[$];
  always @(negedge clk) begin
    mem_ready_b = mem_access_b;
    outblock_b  = read_b ? pat(address_b) : {8{$urandom()}};
    if (mem_access_b && write_b) wr_log_b.push_back(address_b);
    if (mem_access_b && read_b)  rd_log_b.push_back(address_b);
  end

  task automatic check_log(input string name, input logic [15:0] got[$], input logic [15:0] exp[$]);
    check({name, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", name, i), 64'(got[i]), 64'(exp[i]));
  endtask

  // One complete run on instance A, compared against the given expectations.
  task automatic run_a(input string name, input int mid_start, input logic exp_pass,
                       input logic exp_tmo, input int exp_err, input int exp_cycles);
    int n, first_n, req_cycles;
    bit seen;
    logic [15:0] exp_q[$];
    wr_log.delete(); rd_log.delete(); mem.delete(); wr_data_bad = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0; first_n = -1; req_cycles = 0; seen = 1'b0;
    while (n < 400 && !seen) begin
      if (mem_access_a) begin
        req_cycles++;
        if (first_n < 0) first_n = n;
      end
      if (done_a) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
        start_a = (mid_start != 0 && n == mid_start);
      end
    end
    start_a = 1'b0;
    check({name, "_finished"}, 64'(seen), 64'(1));
    check({name, "_done"},     64'(done_a), 64'(1));
    check({name, "_busy"},     64'(busy_a), 64'(0));
    check({name, "_pass"},     64'(pass_a), 64'(exp_pass));
    check({name, "_timeout"},  64'(timeout_a), 64'(exp_tmo));
    check({name, "_memaccess"}, 64'(mem_access_a), 64'(0));
    check({name, "_err_cnt"},  64'(err_a), 64'(exp_err));
    if (exp_tmo) begin
      check({name, "_req_cycles"}, 64'(req_cycles), 64'(TMO));
    end else begin
      for (int i = 0; i < NOPS; i++) exp_q.push_back(addr_ref(16'h1000, i));
      check_log({name, "_wr_addr"}, wr_log, exp_q);
      check_log({name, "_rd_addr"}, rd_log, exp_q);
      check({name, "_wr_data_bad"}, 64'(wr_data_bad), 64'(0));
    end
    if (exp_cycles >= 0)
      check({name, "_cycles"}, 64'(n - first_n), 64'(exp_cycles));
  endtask

  typedef struct {
    string       name;
    int          max_lat;
    int          fix_lat;
    int          noise;
    int          stall;
    int          mid_start;
    bit          corrupt_en;
    logic [15:0] c_addr;
    int          c_bit;
    logic        exp_pass;
    logic        exp_tmo;
    int          exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got no summary expected summary");
    $fatal(1);
  end

  initial begin
    int exp_err;
    int nc;
    logic [15:0] exp_b[$];

    vecs[0] = '{"ideal",        0, 0, 0, 0, 0, 1'b0, 16'h0000, 0,   1'b1, 1'b0, 0, 16};
    vecs[1] = '{"corrupt_1002", 0, 0, 0, 0, 0, 1'b1, 16'h1002, 0,   1'b0, 1'b0, 1, 16};
    vecs[2] = '{"no_ready",     0, 0, 0, 1, 0, 1'b0, 16'h0000, 0,   1'b0, 1'b1, 0, -1};
    vecs[3] = '{"lat7_edge",    7, 1, 0, 0, 0, 1'b0, 16'h0000, 0,   1'b1, 1'b0, 0, 72};
    vecs[4] = '{"corrupt_msb",  3, 0, 0, 0, 0, 1'b1, 16'h1000, 255, 1'b0, 1'b0, 1, -1};
    vecs[5] = '{"noise",        3, 0, 1, 0, 0, 1'b0, 16'h0000, 0,   1'b1, 1'b0, 0, -1};
    vecs[6] = '{"start_busy",   2, 0, 0, 0, 5, 1'b0, 16'h0000, 0,   1'b1, 1'b0, 0, -1};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_write",     64'(write_a), 64'(0));
    check("rst_read",      64'(read_a), 64'(0));
    check("rst_memaccess", 64'(mem_access_a), 64'(0));
    check("rst_address",   64'(address_a), 64'(0));
    check("rst_inblock",   64'(|inblock_a), 64'(0));
    check("rst_busy",      64'(busy_a), 64'(0));
    check("rst_done",      64'(done_a), 64'(0));
    check("rst_pass",      64'(pass_a), 64'(0));
    check("rst_timeout",   64'(timeout_a), 64'(0));
    check("rst_err_cnt",   64'(err_a), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Directed table.
    foreach (vecs[v]) begin
      g_max_lat = vecs[v].max_lat; g_fix_lat = vecs[v].fix_lat;
      g_noise   = vecs[v].noise;   g_stall   = vecs[v].stall;
      corrupt_map.delete();
      if (vecs[v].corrupt_en) corrupt_map[vecs[v].c_addr] = vecs[v].c_bit;
      run_a(vecs[v].name, vecs[v].mid_start, vecs[v].exp_pass, vecs[v].exp_tmo,
            vecs[v].exp_err, vecs[v].exp_cycles);
    end

    // Reset asserted in RD_REQ after an error was already counted.
    g_max_lat = 1; g_fix_lat = 1; g_noise = 0; g_stall = 0;
    corrupt_map.delete(); corrupt_map[16'h1000] = 3;
    mem.delete();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    nc = 0;
    while (nc < 200 && !(read_a && err_a == 16'h0001)) begin
      @(negedge clk); nc++;
    end
    check("mid_rst_reached_rd", 64'(read_a && err_a == 16'h0001), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_memaccess", 64'(mem_access_a), 64'(0));
    check("mid_rst_read",      64'(read_a), 64'(0));
    check("mid_rst_address",   64'(address_a), 64'(0));
    check("mid_rst_busy",      64'(busy_a), 64'(0));
    check("mid_rst_done",      64'(done_a), 64'(0));
    check("mid_rst_err_cnt",   64'(err_a), 64'(0));
    reset = 1'b0;
    corrupt_map.delete();
    run_a("after_reset", 0, 1'b1, 1'b0, 0, -1);

    // Randomized runs against the reference model.
    for (int r = 0; r < 10; r++) begin
      g_max_lat = int'($urandom_range(TMO - 1, 0));
      g_fix_lat = 0;
      g_noise   = int'($urandom_range(1, 0));
      g_stall   = 0;
      corrupt_map.delete();
      nc = int'($urandom_range(3, 0));
      for (int c = 0; c < nc; c++)
        corrupt_map[16'(32'h1000 + $urandom_range(5, 0))] = int'($urandom_range(BW - 1, 0));
      exp_err = 0;
      for (int i = 0; i < NOPS; i++)
        if (corrupt_map.exists(addr_ref(16'h1000, i))) exp_err++;
      run_a($sformatf("rand%0d", r), ($urandom_range(1, 0) != 0) ? int'($urandom_range(20, 1)) : 0,
            (exp_err == 0), 1'b0, exp_err, -1);
    end

    // Wrap-around on instance B.
    wr_log_b.delete(); rd_log_b.delete();
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    nc = 0;
    while (nc < 100 && !done_b) begin
      @(negedge clk); nc++;
    end
    exp_b = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    check("wrap_done",    64'(done_b), 64'(1));
    check("wrap_pass",    64'(pass_b), 64'(1));
    check("wrap_err_cnt", 64'(err_b), 64'(0));
    check("wrap_timeout", 64'(timeout_b), 64'(0));
    check_log("wrap_wr_addr", wr_log_b, exp_b);
    check_log("wrap_rd_addr", rd_log_b, exp_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
